// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of the combinational 32-bit ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [31:0] i_a0,
  input  logic [31:0] i_b0,
  input  logic [31:0] i_a1,
  input  logic [31:0] i_b1,
  input  logic [3:0]  i_ctl0,
  input  logic [3:0]  i_ctl1,
  input  logic [4:0]  i_sa0,
  input  logic [4:0]  i_sa1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_busy,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_control,
  output logic [4:0]  o_alu_sa,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero
);

  // state | meaning
  // IDLE  | no operation in flight, arbitrating
  // EXEC  | ALU computing from operand registers, grant pulse to owner
  // RESP  | result registered, done pulse to owner, arbitrating again
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [4:0]  sa_q, sa_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        any_req, winner;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb winner = ~i_req0;
`else
  logic ptr_q, ptr_d;

  always_comb winner = (i_req0 & i_req1) ? ptr_q : i_req1;
`endif

  assign any_req = i_req0 | i_req1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      sa_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      sa_q     <= sa_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    sa_d     = sa_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_EXEC: begin
        result_d = i_alu_result;
        zero_d   = i_alu_zero;
        state_d  = ST_RESP;
      end
      default: begin
        // IDLE and RESP both arbitrate, giving one op every two cycles when busy
        if (any_req) begin
          state_d = ST_EXEC;
          owner_d = winner;
          a_d     = winner ? i_a1   : i_a0;
          b_d     = winner ? i_b1   : i_b0;
          ctl_d   = winner ? i_ctl1 : i_ctl0;
          sa_d    = winner ? i_sa1  : i_sa0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d   = ~winner;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign o_gnt0        = (state_q == ST_EXEC) && !owner_q;
  assign o_gnt1        = (state_q == ST_EXEC) &&  owner_q;
  assign o_done0       = (state_q == ST_RESP) && !owner_q;
  assign o_done1       = (state_q == ST_RESP) &&  owner_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_result      = result_q;
  assign o_zero        = zero_q;
  assign o_alu_a       = a_q;
  assign o_alu_b       = b_q;
  assign o_alu_control = ctl_q;
  assign o_alu_sa      = sa_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;

  logic        clk, rst_n;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  ctl0, ctl1;
  logic [4:0]  sa0, sa1;
  logic        gnt0, gnt1, done0, done1, zero, busy;
  logic [31:0] result, alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctl;
  logic [4:0]  alu_sa;
  logic        alu_zero;

  int compared = 0;
  int mismatched = 0;

  alu_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1),
    .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
    .i_ctl0(ctl0), .i_ctl1(ctl1), .i_sa0(sa0), .i_sa1(sa1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_result(result), .o_zero(zero), .o_busy(busy),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_control(alu_ctl), .o_alu_sa(alu_sa),
    .i_alu_result(alu_res), .i_alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real one
  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] s);
    case (c[2:0])
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return c[3] ? a - b : a + b;
      3'b011:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return b << s;
      3'b101:  return b >> s;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_ctl, alu_a, alu_b, alu_sa);
  assign alu_zero = (alu_res == 32'd0);

  // Transaction model: an op granted at one edge completes at the next; the ALU is
  // free to take a new op whenever no op was granted at the previous edge.
  bit          m_exec, m_resp, m_owner, m_resp_owner, m_last;
  logic [31:0] m_a, m_b, m_result;
  logic [3:0]  m_ctl;
  logic [4:0]  m_sa;
  logic        m_zero;
  bit          drop_en, reraise_en;
  int          gnt_hist[$];

  task automatic model_reset();
    m_exec = 0; m_resp = 0; m_owner = 0; m_resp_owner = 0;
    m_last = 1;
    m_a = '0; m_b = '0; m_ctl = '0; m_sa = '0;
    m_result = '0; m_zero = 1'b0;
  endtask

  task automatic model_edge();
    bit w;
    if (m_exec) begin
      m_result     = alu_f(m_ctl, m_a, m_b, m_sa);
      m_zero       = (m_result == 32'd0);
      m_resp_owner = m_owner;
      m_exec       = 0;
      m_resp       = 1;
    end else begin
      m_resp = 0;
      if (req0 || req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = !req0;
`else
        w = (req0 && req1) ? !m_last : req1;
`endif
        m_last  = w;
        m_owner = w;
        m_a   = w ? a1 : a0;
        m_b   = w ? b1 : b0;
        m_ctl = w ? ctl1 : ctl0;
        m_sa  = w ? sa1 : sa0;
        m_exec = 1;
        gnt_hist.push_back(int'(w));
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("gnt0",   32'(gnt0),  32'(m_exec && !m_owner));
    chk("gnt1",   32'(gnt1),  32'(m_exec &&  m_owner));
    chk("done0",  32'(done0), 32'(m_resp && !m_resp_owner));
    chk("done1",  32'(done1), 32'(m_resp &&  m_resp_owner));
    chk("busy",   32'(busy),  32'(m_exec || m_resp));
    chk("result", result,     m_result);
    chk("zero",   32'(zero),  32'(m_zero));
    chk("alu_a",  alu_a,      m_a);
    chk("alu_b",  alu_b,      m_b);
    chk("alu_ctl", 32'(alu_ctl), 32'(m_ctl));
    chk("alu_sa", 32'(alu_sa), 32'(m_sa));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (drop_en && m_exec) begin
      if (!m_owner) req0 = 1'b0; else req1 = 1'b0;
    end
    if (reraise_en && m_resp) begin
      if (!m_resp_owner) req0 = 1'b1; else req1 = 1'b1;
    end
  endtask

  initial begin
    int n;
    req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ctl0 = '0; ctl1 = '0; sa0 = '0; sa1 = '0;
    drop_en = 1; reraise_en = 0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_all();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single add
    a0 = 5; b0 = 7; ctl0 = 4'b0010; req0 = 1;
    cycle();
    chk("add_gnt0", 32'(gnt0), 32'd1);
    chk("add_alu_a", alu_a, 32'd5);
    cycle();
    chk("add_done0", 32'(done0), 32'd1);
    chk("add_result", result, 32'd12);
    chk("add_zero", 32'(zero), 32'd0);
    cycle();

    // Subtract to zero
    a1 = 32'h1234; b1 = 32'h1234; ctl1 = 4'b1010; req1 = 1;
    cycle(); cycle();
    chk("sub_done1", 32'(done1), 32'd1);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    cycle();

    // Simultaneous requests, re-raised on every done
    a0 = 1; b0 = 1; ctl0 = 4'b0010;
    a1 = 32'hFFFF_FFFF; b1 = 0; ctl1 = 4'b1011;
    gnt_hist.delete();
    req0 = 1; req1 = 1; reraise_en = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (m_resp) chk("simul_result", result, m_resp_owner ? 32'd1 : 32'd2);
    end
    reraise_en = 0; req0 = 0; req1 = 0;
    cycle(); cycle();
    chk("simul_count", 32'(gnt_hist.size()), 32'd4);
    for (int i = 0; i < gnt_hist.size(); i++)
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("simul_order", 32'(gnt_hist[i]), 32'd0);
`else
      chk("simul_order", 32'(gnt_hist[i]), 32'(i % 2));
`endif

    // Back-to-back shifts from requester 0
    a0 = 0; b0 = 1; sa0 = 31; ctl0 = 4'b0100; req0 = 1;
    cycle(); cycle();
    chk("b2b_result", result, 32'h8000_0000);
    req0 = 1; sa0 = 3;
    cycle();
    chk("b2b_gnt0", 32'(gnt0), 32'd1);
    cycle();
    chk("b2b_result2", result, 32'd8);
    cycle();

    // Reset during EXEC
    a0 = 9; b0 = 9; ctl0 = 4'b0010; req0 = 1;
    cycle();
    #1 rst_n = 1'b0;
    req0 = 0; req1 = 0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
    cycle();
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_result", result, 32'd0);
    a0 = 2; b0 = 3; a1 = 4; b1 = 5; ctl0 = 4'b0001; ctl1 = 4'b0000;
    req0 = 1; req1 = 1;
    cycle();
    chk("rst_gnt0", 32'(gnt0), 32'd1);
    req1 = 0;
    cycle(); cycle();

    // Late drop: req0 held through RESP is a fresh request
    drop_en = 0;
    a0 = 32'd100; b0 = 32'd50; ctl0 = 4'b1010; req0 = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (gnt0) n++;
    end
    chk("late_gnt_count", 32'(n), 32'd2);
    req0 = 0; drop_en = 1;
    cycle(); cycle();

    // Random traffic, protocol-compliant requesters
    for (int i = 0; i < 400; i++) begin
      if (!req0 && $urandom_range(1, 0) == 1) begin
        a0 = $urandom; b0 = $urandom; ctl0 = 4'($urandom); sa0 = 5'($urandom); req0 = 1;
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
        a1 = $urandom; b1 = $urandom; ctl1 = 4'($urandom); sa1 = 5'($urandom); req1 = 1;
      end
      cycle();
    end
    req0 = 0; req1 = 0;
    cycle(); cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
